// File: rtl/mem_access_unit_if.sv
// Request/response bundle between a load/store requester and mem_access_unit.
// Handshake: start is sampled only while busy is low; an accepted request produces exactly one done pulse.
interface mem_access_unit_if;
  logic        start;
  logic        load_store;
  logic        pre_post;
  logic        up_down;
  logic        byte_word;
  logic        write_back;
  logic [11:0] offset;
  logic [31:0] base_data;
  logic [31:0] store_data;
  logic [3:0]  rd;
  logic [3:0]  rn;
  logic        busy;
  logic        done;
  logic        rd_we;
  logic [3:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        rn_we;
  logic [3:0]  rn_waddr;
  logic [31:0] rn_wdata;
  logic [1:0]  dbg_state;
  logic [31:0] dbg_eff_addr;

  modport master (
    output start, load_store, pre_post, up_down, byte_word, write_back,
           offset, base_data, store_data, rd, rn,
    input  busy, done, rd_we, rd_waddr, rd_wdata, rn_we, rn_waddr, rn_wdata,
           dbg_state, dbg_eff_addr
  );

  modport slave (
    input  start, load_store, pre_post, up_down, byte_word, write_back,
           offset, base_data, store_data, rd, rn,
    output busy, done, rd_we, rd_waddr, rd_wdata, rn_we, rn_waddr, rn_wdata,
           dbg_state, dbg_eff_addr
  );
endinterface

// File: rtl/mem_access_unit.sv
// Single-issue LDR/STR unit with immediate offset, pre/post indexing and base write-back.
// Four fixed stages IDLE -> ADDR -> MEM -> WB over a private word-addressed data memory.
module mem_access_unit #(
  parameter int MEM_WORDS_LOG2 = 8
) (
  input  logic             clk,
  input  logic             nreset,
  mem_access_unit_if.slave bus
);
  localparam int MEM_DEPTH = 1 << MEM_WORDS_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    MEM  = 2'd2,
    WB   = 2'd3
  } state_e;

  state_e      state_q;
  logic        ls_q, pre_q, up_q, byte_q, wb_q;
  logic [11:0] offset_q;
  logic [31:0] base_q, sdata_q;
  logic [3:0]  rd_q, rn_q;
  logic [31:0] offset_addr_q, eff_addr_q;
  logic        done_q, rd_we_q, rn_we_q;
  logic [3:0]  rd_waddr_q, rn_waddr_q;
  logic [31:0] rd_wdata_q, rn_wdata_q;

  logic [31:0] mem_q [MEM_DEPTH];

  logic [31:0]               offset_sum;
  logic [MEM_WORDS_LOG2-1:0] mem_idx;
  logic [4:0]                lane_bit;
  logic [31:0]               rdata_word;
  logic [31:0]               load_result;
  logic [31:0]               wr_word;
  logic                      rn_we_next;

  always_comb begin
    offset_sum  = up_q ? (base_q + {20'd0, offset_q}) : (base_q - {20'd0, offset_q});
    mem_idx     = eff_addr_q[MEM_WORDS_LOG2+1:2];
    lane_bit    = {eff_addr_q[1:0], 3'b000};
    rdata_word  = mem_q[mem_idx];
    load_result = byte_q ? {24'd0, rdata_word[lane_bit +: 8]} : rdata_word;
    // Byte stores merge into the current word so untouched lanes keep their value.
    wr_word     = sdata_q;
    if (byte_q) begin
      wr_word               = rdata_word;
      wr_word[lane_bit +: 8] = sdata_q[7:0];
    end
    // A load into the base register takes priority over the base update.
    rn_we_next  = (pre_q ? wb_q : 1'b1) && !(ls_q && (rd_q == rn_q));
  end

  always_ff @(posedge clk) begin
    if (state_q == MEM && !ls_q) begin
      mem_q[mem_idx] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= IDLE;
      ls_q          <= 1'b0;
      pre_q         <= 1'b0;
      up_q          <= 1'b0;
      byte_q        <= 1'b0;
      wb_q          <= 1'b0;
      offset_q      <= '0;
      base_q        <= '0;
      sdata_q       <= '0;
      rd_q          <= '0;
      rn_q          <= '0;
      offset_addr_q <= '0;
      eff_addr_q    <= '0;
      done_q        <= 1'b0;
      rd_we_q       <= 1'b0;
      rd_waddr_q    <= '0;
      rd_wdata_q    <= '0;
      rn_we_q       <= 1'b0;
      rn_waddr_q    <= '0;
      rn_wdata_q    <= '0;
    end else begin
      done_q     <= 1'b0;
      rd_we_q    <= 1'b0;
      rd_waddr_q <= '0;
      rd_wdata_q <= '0;
      rn_we_q    <= 1'b0;
      rn_waddr_q <= '0;
      rn_wdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            ls_q     <= bus.load_store;
            pre_q    <= bus.pre_post;
            up_q     <= bus.up_down;
            byte_q   <= bus.byte_word;
            wb_q     <= bus.write_back;
            offset_q <= bus.offset;
            base_q   <= bus.base_data;
            sdata_q  <= bus.store_data;
            rd_q     <= bus.rd;
            rn_q     <= bus.rn;
            state_q  <= ADDR;
          end
        end
        ADDR: begin
          offset_addr_q <= offset_sum;
          eff_addr_q    <= pre_q ? offset_sum : base_q;
          state_q       <= MEM;
        end
        MEM: begin
          // Outputs are registered here so they are valid throughout WB.
          done_q <= 1'b1;
          if (ls_q) begin
            rd_we_q    <= 1'b1;
            rd_waddr_q <= rd_q;
            rd_wdata_q <= load_result;
          end
          if (rn_we_next) begin
            rn_we_q    <= 1'b1;
            rn_waddr_q <= rn_q;
            rn_wdata_q <= offset_addr_q;
          end
          state_q <= WB;
        end
        WB: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
  assign bus.rd_we        = rd_we_q;
  assign bus.rd_waddr     = rd_waddr_q;
  assign bus.rd_wdata     = rd_wdata_q;
  assign bus.rn_we        = rn_we_q;
  assign bus.rn_waddr     = rn_waddr_q;
  assign bus.rn_wdata     = rn_wdata_q;
  assign bus.dbg_state    = state_q;
  assign bus.dbg_eff_addr = eff_addr_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a reference model predicts each completion,
// which is queued at issue and compared when done pulses.
module tb_mem_access_unit;
  localparam int W = 106;

  logic clk;
  logic nreset;
  int   cyc;
  int   tests;
  int   fails;

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_WORDS_LOG2(8)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  // Expected item: {eff_addr, rd_we, rd_waddr, rd_wdata, rn_we, rn_waddr, rn_wdata}
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  logic [31:0]  mem_m [256];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (nreset) begin
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("extra_done", 32'd1, 32'd0);
        end else begin
          logic [W-1:0] e;
          int           a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("done_edge", 32'(cyc + 1 - a), 32'd3);
          check("eff_addr", bus.dbg_eff_addr, e[105:74]);
          check("rd_we", {31'd0, bus.rd_we}, {31'd0, e[73]});
          if (e[73]) begin
            check("rd_waddr", {28'd0, bus.rd_waddr}, {28'd0, e[72:69]});
            check("rd_wdata", bus.rd_wdata, e[68:37]);
          end
          check("rn_we", {31'd0, bus.rn_we}, {31'd0, e[36]});
          if (e[36]) begin
            check("rn_waddr", {28'd0, bus.rn_waddr}, {28'd0, e[35:32]});
            check("rn_wdata", bus.rn_wdata, e[31:0]);
          end
        end
      end else begin
        check("we_quiet", {30'd0, bus.rd_we, bus.rn_we}, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_inputs(input bit ls, pre, up, byt, wb, input logic [11:0] off,
                              input logic [31:0] base, sd, input logic [3:0] rd, rn);
    bus.load_store = ls;
    bus.pre_post   = pre;
    bus.up_down    = up;
    bus.byte_word  = byt;
    bus.write_back = wb;
    bus.offset     = off;
    bus.base_data  = base;
    bus.store_data = sd;
    bus.rd         = rd;
    bus.rn         = rn;
  endtask

  task automatic do_op(input bit ls, pre, up, byt, wb, input logic [11:0] off,
                       input logic [31:0] base, sd, input logic [3:0] rd, rn,
                       input bit abort, output int acc);
    logic [31:0] oa, eff, data;
    logic [7:0]  idx;
    logic [4:0]  lb;
    bit          rnw, got;
    oa   = up ? base + {20'd0, off} : base - {20'd0, off};
    eff  = pre ? oa : base;
    idx  = eff[9:2];
    lb   = {eff[1:0], 3'b000};
    data = byt ? {24'd0, mem_m[idx][lb +: 8]} : mem_m[idx];
    rnw  = (pre ? wb : 1'b1) && !(ls && rd == rn);
    @(negedge clk);
    drive_inputs(ls, pre, up, byt, wb, off, base, sd, rd, rn);
    bus.start = 1'b1;
    got = 1'b0;
    acc = -1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.dbg_state == 2'd1) begin
        got = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
    if (!got) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    acc = cyc;
    if (!abort) begin
      if (!ls) begin
        if (byt) mem_m[idx][lb +: 8] = sd[7:0];
        else     mem_m[idx] = sd;
      end
      exp_q.push_back({eff, ls, rd, ls ? data : 32'd0, rnw, rn, oa});
      acc_q.push_back(acc);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!bus.busy) return;
    end
    check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic pulse_while_busy();
    @(negedge clk);
    drive_inputs(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'd0, 32'd0, 32'hFFFF_FFFF, 4'd9, 4'd9);
    bus.start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic reset_in_mem(input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.dbg_state == 2'd2) begin
        hit = 1'b1;
        break;
      end
    end
    check({tag, "_reach_mem"}, {31'd0, hit}, 32'd1);
    nreset = 1'b0;
    #1;
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_flags"}, {29'd0, bus.done, bus.rd_we, bus.rn_we}, 32'd0);
    check({tag, "_wdata"}, bus.rd_wdata | bus.rn_wdata, 32'd0);
    check({tag, "_state"}, {30'd0, bus.dbg_state}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a1, a2, a;
    logic [31:0] base;
    logic [11:0] off;
    bit up;
    tests  = 0;
    fails  = 0;
    nreset = 1'b0;
    bus.start = 1'b0;
    drive_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 32'd0, 32'd0, 4'd0, 4'd0);
    for (int i = 0; i < 256; i++) mem_m[i] = 32'd0;
    #3;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_flags", {29'd0, bus.done, bus.rd_we, bus.rn_we}, 32'd0);
    check("rst_addr", {24'd0, bus.rd_waddr, bus.rn_waddr}, 32'd0);
    check("rst_wdata", bus.rd_wdata | bus.rn_wdata, 32'd0);
    check("rst_state", {30'd0, bus.dbg_state}, 32'd0);
    repeat (3) @(negedge clk);
    nreset = 1'b1;

    // STR word pre-index with write-back, then byte load of lane 1
    do_op(0, 1, 1, 0, 1, 12'd4, 32'h100, 32'hDEAD_BEEF, 4'd0, 4'd2, 0, a); wait_idle();
    do_op(1, 1, 1, 1, 0, 12'd5, 32'h100, 32'd0, 4'd3, 4'd1, 0, a); wait_idle();
    // Post-index word load, base decremented
    do_op(1, 0, 0, 0, 0, 12'd8, 32'h104, 32'd0, 4'd4, 4'd6, 0, a); wait_idle();
    // Address wrap below zero lands in the last word
    do_op(0, 1, 0, 0, 1, 12'd4, 32'h0, 32'hCAFE_F00D, 4'd0, 4'd7, 0, a); wait_idle();
    do_op(0, 1, 1, 1, 0, 12'd0, 32'h3FF, 32'h0000_005A, 4'd0, 4'd7, 0, a); wait_idle();
    do_op(1, 1, 1, 0, 0, 12'd0, 32'h3FC, 32'd0, 4'd8, 4'd7, 0, a); wait_idle();
    // Load into its own base register; start pulsed while busy must be ignored
    do_op(1, 1, 1, 0, 1, 12'd4, 32'h100, 32'd0, 4'd5, 4'd5, 0, a);
    pulse_while_busy();
    wait_idle();
    repeat (3) @(negedge clk);

    // Back-to-back: second start held high until taken
    do_op(0, 1, 1, 1, 0, 12'd6, 32'h100, 32'h0000_0077, 4'd0, 4'd1, 0, a1);
    do_op(1, 0, 1, 0, 1, 12'd3, 32'h104, 32'd0, 4'd2, 4'd3, 0, a2);
    check("b2b_spacing", 32'(a2 - a1), 32'd4);
    wait_idle();

    // Prefill words 0..31, then random mixed traffic in that window
    for (int i = 0; i < 32; i++) begin
      do_op(0, 1, 1, 0, 0, 12'd0, 32'(i * 4), $urandom, 4'd0, 4'd1, 0, a);
      wait_idle();
    end
    for (int i = 0; i < 24; i++) begin
      base = 32'($urandom_range(0, 63));
      up   = 1'($urandom_range(0, 1));
      off  = up ? 12'($urandom_range(0, 63)) : 12'($urandom_range(0, int'(base)));
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), up, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), off, base, $urandom,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0, a);
      wait_idle();
    end

    // Reset during MEM: aborted load, aborted store leaves memory intact
    do_op(1, 1, 1, 0, 1, 12'd4, 32'h100, 32'd0, 4'd3, 4'd2, 1, a);
    reset_in_mem("abort_ldr");
    do_op(0, 1, 1, 0, 1, 12'd0, 32'h8, 32'h1111_1111, 4'd0, 4'd2, 1, a);
    reset_in_mem("abort_str");
    do_op(1, 1, 1, 0, 0, 12'd0, 32'h8, 32'd0, 4'd6, 4'd2, 0, a); wait_idle();
    repeat (2) @(negedge clk);

    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
